// File: rtl/mem_stage_lsu.sv
// mem_stage_lsu
//   Load/store unit for the MEM stage. It takes a load or store from the EX/MEM
//   register, issues a valid/ready request on the data bus, and holds the
//   pipeline with o_StallM until the access finishes. Load data is aligned and
//   extended for the MEM/WB register.
//
// Ports
//   i_Clk, i_Reset      clock; synchronous active-low reset
//   i_ALUResultM        effective byte address
//   i_WriteDataM        store data (rs2)
//   i_MemReadM/WriteM   load / store present in MEM
//   i_Funct3M           access size and sign: b, h, w, bu, hu
//   o_BusValid..BusBe   request channel, held stable until accepted
//   i_BusReady          request accepted when valid && ready
//   i_BusRValid/RData   read response, counted from the cycle after accept
//   o_ReadDataM         extended load result, held until the next capture
//   o_StallM            freezes PC/IF/ID/EX/MEM while the access is in flight
//   o_MisalignedM       one-cycle pulse, misaligned access, no bus activity
//   o_AccessFaultM      one-cycle pulse, illegal op or bus timeout
`timescale 1ns/1ps
module mem_stage_lsu #(
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic        i_Clk,
    input  logic        i_Reset,
    input  logic [31:0] i_ALUResultM,
    input  logic [31:0] i_WriteDataM,
    input  logic        i_MemReadM,
    input  logic        i_MemWriteM,
    input  logic [2:0]  i_Funct3M,
    output logic        o_BusValid,
    input  logic        i_BusReady,
    output logic        o_BusWe,
    output logic [31:0] o_BusAddr,
    output logic [31:0] o_BusWData,
    output logic [3:0]  o_BusBe,
    input  logic        i_BusRValid,
    input  logic [31:0] i_BusRData,
    output logic [31:0] o_ReadDataM,
    output logic        o_StallM,
    output logic        o_MisalignedM,
    output logic        o_AccessFaultM
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2,
        DONE = 2'd3
    } state_t;

    // Last counter value before the access is abandoned.
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

    function automatic logic [3:0] store_be(input logic [1:0] sz, input logic [1:0] off);
        logic [3:0] be;
        case (sz)
            2'b00:   be = 4'b0001 << off;
            2'b01:   be = 4'b0011 << off;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    // Replicating the data into every lane lets the slave pick lanes by be alone.
    function automatic logic [31:0] store_wdata(input logic [1:0] sz, input logic [31:0] wd);
        logic [31:0] w;
        case (sz)
            2'b00:   w = {4{wd[7:0]}};
            2'b01:   w = {2{wd[15:0]}};
            default: w = wd;
        endcase
        return w;
    endfunction

    function automatic logic [31:0] load_ext(input logic [2:0] f3, input logic [1:0] off,
                                             input logic [31:0] w);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        case (off)
            2'd0:    b = w[7:0];
            2'd1:    b = w[15:8];
            2'd2:    b = w[23:16];
            default: b = w[31:24];
        endcase
        h = off[1] ? w[31:16] : w[15:0];
        case (f3)
            3'b000:  r = {{24{b[7]}}, b};
            3'b001:  r = {{16{h[15]}}, h};
            3'b100:  r = {24'd0, b};
            3'b101:  r = {16'd0, h};
            default: r = w;
        endcase
        return r;
    endfunction

    state_t      state_q;
    logic [7:0]  cnt_q;
    logic [31:0] addr_q;
    logic        we_q;
    logic [3:0]  be_q;
    logic [31:0] wdata_q;
    logic [2:0]  f3_q;
    logic [1:0]  off_q;
    logic [31:0] rdata_q;
    logic        tmo_q;

    logic op;
    logic legal;
    logic aligned;
    logic idle_op;
    logic issue;

    assign op = i_MemReadM | i_MemWriteM;

    always_comb begin
        legal = 1'b0;
        if (!(i_MemReadM && i_MemWriteM)) begin
            case (i_Funct3M)
                3'b000, 3'b001, 3'b010: legal = 1'b1;
                3'b100, 3'b101:         legal = i_MemReadM;
                default:                legal = 1'b0;
            endcase
        end
    end

    always_comb begin
        aligned = 1'b1;
        case (i_Funct3M[1:0])
            2'b00:   aligned = 1'b1;
            2'b01:   aligned = ~i_ALUResultM[0];
            default: aligned = (i_ALUResultM[1:0] == 2'b00);
        endcase
    end

    // Gated by reset so every output reads 0 while reset is held.
    assign idle_op = i_Reset && (state_q == IDLE) && op;
    assign issue   = idle_op && legal && aligned;

    always_ff @(posedge i_Clk) begin
        if (!i_Reset) begin
            state_q <= IDLE;
            cnt_q   <= 8'd0;
            addr_q  <= 32'd0;
            we_q    <= 1'b0;
            be_q    <= 4'd0;
            wdata_q <= 32'd0;
            f3_q    <= 3'd0;
            off_q   <= 2'd0;
            rdata_q <= 32'd0;
            tmo_q   <= 1'b0;
        end else begin
            tmo_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (issue) begin
                        state_q <= REQ;
                        cnt_q   <= 8'd0;
                        addr_q  <= {i_ALUResultM[31:2], 2'b00};
                        we_q    <= i_MemWriteM;
                        be_q    <= i_MemWriteM ? store_be(i_Funct3M[1:0], i_ALUResultM[1:0])
                                               : 4'b1111;
                        wdata_q <= i_MemWriteM ? store_wdata(i_Funct3M[1:0], i_WriteDataM)
                                               : 32'd0;
                        f3_q    <= i_Funct3M;
                        off_q   <= i_ALUResultM[1:0];
                    end
                end
                REQ: begin
                    cnt_q <= cnt_q + 8'd1;
                    if (i_BusReady) begin
                        state_q <= we_q ? DONE : RESP;
                    end else if (cnt_q == TMO_LAST) begin
                        state_q <= DONE;
                        tmo_q   <= 1'b1;
                        rdata_q <= 32'd0;
                    end
                end
                RESP: begin
                    cnt_q <= cnt_q + 8'd1;
                    if (i_BusRValid) begin
                        state_q <= DONE;
                        rdata_q <= load_ext(f3_q, off_q, i_BusRData);
                    end else if (cnt_q == TMO_LAST) begin
                        state_q <= DONE;
                        tmo_q   <= 1'b1;
                        rdata_q <= 32'd0;
                    end
                end
                DONE: begin
                    // Op is ignored here: the pipeline advances this cycle.
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign o_BusValid     = (state_q == REQ);
    assign o_BusWe        = we_q;
    assign o_BusAddr      = addr_q;
    assign o_BusWData     = wdata_q;
    assign o_BusBe        = be_q;
    assign o_ReadDataM    = rdata_q;
    assign o_StallM       = issue || (state_q == REQ) || (state_q == RESP);
    assign o_MisalignedM  = idle_op && legal && !aligned;
    assign o_AccessFaultM = (idle_op && !legal) || tmo_q;

endmodule

// File: tb/tb_mem_stage_lsu.sv
`timescale 1ns/1ps
module tb_mem_stage_lsu;

    localparam int TO    = 64;
    localparam int NEVER = 1000;

    logic        clk = 1'b0;
    logic        i_Reset = 1'b0;
    logic [31:0] i_ALUResultM = '0;
    logic [31:0] i_WriteDataM = '0;
    logic        i_MemReadM = 1'b0;
    logic        i_MemWriteM = 1'b0;
    logic [2:0]  i_Funct3M = '0;
    logic        i_BusReady = 1'b0;
    logic        i_BusRValid = 1'b0;
    logic [31:0] i_BusRData = '0;
    logic        o_BusValid, o_BusWe, o_StallM, o_MisalignedM, o_AccessFaultM;
    logic [31:0] o_BusAddr, o_BusWData, o_ReadDataM;
    logic [3:0]  o_BusBe;

    always #5 clk = ~clk;

    mem_stage_lsu #(.TIMEOUT_CYCLES(TO)) dut (
        .i_Clk(clk), .i_Reset(i_Reset),
        .i_ALUResultM(i_ALUResultM), .i_WriteDataM(i_WriteDataM),
        .i_MemReadM(i_MemReadM), .i_MemWriteM(i_MemWriteM), .i_Funct3M(i_Funct3M),
        .o_BusValid(o_BusValid), .i_BusReady(i_BusReady), .o_BusWe(o_BusWe),
        .o_BusAddr(o_BusAddr), .o_BusWData(o_BusWData), .o_BusBe(o_BusBe),
        .i_BusRValid(i_BusRValid), .i_BusRData(i_BusRData),
        .o_ReadDataM(o_ReadDataM), .o_StallM(o_StallM),
        .o_MisalignedM(o_MisalignedM), .o_AccessFaultM(o_AccessFaultM)
    );

    typedef struct {
        logic        stall, valid, misal, fault, we;
        logic [31:0] addr, wdata, rdata;
        logic [3:0]  be;
    } exp_t;

    exp_t        expq[$];
    exp_t        cur_e;
    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] cur_rd  = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model (size/offset arithmetic) ----------------
    function automatic int m_size(input logic [2:0] f3);
        return (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    endfunction

    function automatic bit m_legal(input bit rd, input bit wr, input logic [2:0] f3);
        if (rd && wr) return 1'b0;
        if (f3 == 3'b000 || f3 == 3'b001 || f3 == 3'b010) return 1'b1;
        if (f3 == 3'b100 || f3 == 3'b101) return rd;
        return 1'b0;
    endfunction

    function automatic bit m_aligned(input logic [2:0] f3, input logic [31:0] a);
        return (int'(a[1:0]) % m_size(f3)) == 0;
    endfunction

    function automatic logic [3:0] m_be(input bit wr, input logic [2:0] f3, input logic [31:0] a);
        logic [3:0] be;
        int o, sz;
        if (!wr) return 4'b1111;
        be = '0;
        o  = int'(a[1:0]);
        sz = m_size(f3);
        for (int i = 0; i < 4; i++) be[i] = (i >= o) && (i < o + sz);
        return be;
    endfunction

    function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] wd);
        logic [31:0] w;
        int sz;
        sz = m_size(f3);
        w  = '0;
        for (int i = 0; i < 4; i++) w[8*i +: 8] = wd[8*(i % sz) +: 8];
        return w;
    endfunction

    function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a,
                                           input logic [31:0] rw);
        longint v, span;
        int sz;
        sz   = m_size(f3);
        span = longint'(1) << (8 * sz);
        v    = (longint'(rw) >> (8 * int'(a[1:0]))) % span;
        if (!f3[2] && sz < 4 && v >= span / 2) v = v - span;
        return 32'(v);
    endfunction

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (expq.size() > 0) begin
            cur_e = expq.pop_front();
            chk("stall", 32'(o_StallM), 32'(cur_e.stall));
            chk("bus_valid", 32'(o_BusValid), 32'(cur_e.valid));
            chk("misaligned", 32'(o_MisalignedM), 32'(cur_e.misal));
            chk("access_fault", 32'(o_AccessFaultM), 32'(cur_e.fault));
            chk("read_data", o_ReadDataM, cur_e.rdata);
            if (cur_e.valid) begin
                chk("bus_we", 32'(o_BusWe), 32'(cur_e.we));
                chk("bus_addr", o_BusAddr, cur_e.addr);
                chk("bus_be", 32'(o_BusBe), 32'(cur_e.be));
                if (cur_e.we) chk("bus_wdata", o_BusWData, cur_e.wdata);
            end
        end
    end

    task automatic push(input bit stall, input bit valid, input bit misal, input bit fault,
                        input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] be);
        exp_t e;
        e.stall = stall; e.valid = valid; e.misal = misal; e.fault = fault; e.we = we;
        e.addr = addr; e.wdata = wdata; e.be = be; e.rdata = cur_rd;
        expq.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        i_MemReadM = 1'b0; i_MemWriteM = 1'b0; i_Funct3M = '0;
        i_ALUResultM = '0; i_WriteDataM = '0;
        i_BusReady = 1'b0; i_BusRValid = 1'b0; i_BusRData = '0;
    endtask

    task automatic chk_zero(input string nm);
        @(negedge clk);
        chk({nm, "_addr"}, o_BusAddr, 32'd0);
        chk({nm, "_wdata"}, o_BusWData, 32'd0);
        chk({nm, "_be"}, 32'(o_BusBe), 32'd0);
        chk({nm, "_we"}, 32'(o_BusWe), 32'd0);
        chk({nm, "_valid"}, 32'(o_BusValid), 32'd0);
        chk({nm, "_rdata"}, o_ReadDataM, 32'd0);
    endtask

    // rdy: valid cycles before ready; rv: cycles from accept to rvalid.
    task automatic do_access(input bit rd, input bit wr, input logic [2:0] f3,
                             input logic [31:0] a, input logic [31:0] wd,
                             input int rdy, input int rv, input logic [31:0] rw, input bit junk);
        int accept_k, rv_k, done_k, valid_end;
        bit tmo;
        logic [31:0] eaddr, ewd, new_rd;
        logic [3:0]  ebe;
        if (!m_legal(rd, wr, f3) || !m_aligned(f3, a)) begin
            step();
            i_MemReadM = rd; i_MemWriteM = wr; i_Funct3M = f3;
            i_ALUResultM = a; i_WriteDataM = wd;
            push(1'b0, 1'b0, m_legal(rd, wr, f3), !m_legal(rd, wr, f3), 1'b0, '0, '0, '0);
            step();
            idle_in();
            push(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0);
            return;
        end
        tmo = 1'b0; rv_k = -1;
        accept_k = 1 + rdy;
        if (accept_k > TO) begin
            tmo = 1'b1; valid_end = TO; done_k = TO + 1;
        end else begin
            valid_end = accept_k;
            if (wr) done_k = accept_k + 1;
            else begin
                rv_k = accept_k + rv;
                if (rv_k > TO) begin tmo = 1'b1; done_k = TO + 1; end
                else done_k = rv_k + 1;
            end
        end
        eaddr  = {a[31:2], 2'b00};
        ebe    = m_be(wr, f3, a);
        ewd    = m_wdata(f3, wd);
        new_rd = tmo ? 32'd0 : (wr ? cur_rd : m_load(f3, a, rw));
        for (int k = 0; k <= done_k + 1; k++) begin
            step();
            if (k <= done_k) begin
                i_MemReadM = rd; i_MemWriteM = wr; i_Funct3M = f3;
                i_ALUResultM = a; i_WriteDataM = wd;
            end else begin
                idle_in();
            end
            i_BusReady  = (k == accept_k);
            i_BusRValid = (k == rv_k) || (junk && k == accept_k);
            i_BusRData  = (k == rv_k) ? rw : ~rw;
            if (k == done_k) cur_rd = new_rd;
            push(k < done_k, (k >= 1) && (k <= valid_end), 1'b0, tmo && (k == done_k),
                 wr, eaddr, ewd, ebe);
        end
    endtask

    initial begin
        // Hand-computed values pinning the model.
        chk("pin_sb_be", 32'(m_be(1'b1, 3'b000, 32'h103)), 32'h8);
        chk("pin_sb_wdata", m_wdata(3'b000, 32'h000000A5), 32'hA5A5A5A5);
        chk("pin_sh_be", 32'(m_be(1'b1, 3'b001, 32'h102)), 32'hC);
        chk("pin_lb", m_load(3'b000, 32'h202, 32'h1280FF34), 32'hFFFFFF80);
        chk("pin_lbu", m_load(3'b100, 32'h202, 32'h1280FF34), 32'h00000080);
        chk("pin_lh", m_load(3'b001, 32'h202, 32'h8001ABCD), 32'hFFFF8001);
        chk("pin_lh_misaligned", 32'(m_aligned(3'b001, 32'h201)), 32'd0);
        chk("pin_f3_011_illegal", 32'(m_legal(1'b1, 1'b0, 3'b011)), 32'd0);

        // Reset state.
        idle_in();
        for (int i = 0; i < 3; i++) begin
            step();
            push(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0);
        end
        chk_zero("reset");
        step();
        i_Reset = 1'b1;
        push(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0);

        // Stores.
        do_access(1'b0, 1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 1, 0, 32'h0, 1'b0);
        do_access(1'b0, 1'b1, 3'b000, 32'h103, 32'h000000A5, 0, 0, 32'h0, 1'b0);
        do_access(1'b0, 1'b1, 3'b001, 32'h102, 32'h1234BEEF, 0, 0, 32'h0, 1'b0);

        // Loads; the first also drives a stray rvalid in its accept cycle.
        do_access(1'b1, 1'b0, 3'b000, 32'h202, 32'h0, 0, 3, 32'h1280FF34, 1'b1);
        chk("lb_literal", o_ReadDataM, 32'hFFFFFF80);
        do_access(1'b1, 1'b0, 3'b100, 32'h202, 32'h0, 0, 3, 32'h1280FF34, 1'b0);
        chk("lbu_literal", o_ReadDataM, 32'h00000080);
        do_access(1'b1, 1'b0, 3'b001, 32'h202, 32'h0, 1, 1, 32'h8001ABCD, 1'b0);
        do_access(1'b1, 1'b0, 3'b101, 32'h200, 32'h0, 0, 2, 32'h1234F00D, 1'b0);
        chk("lhu_literal", o_ReadDataM, 32'h0000F00D);
        do_access(1'b1, 1'b0, 3'b010, 32'h204, 32'h0, 2, 1, 32'hCAFEF00D, 1'b0);

        // Misaligned and illegal requests.
        do_access(1'b1, 1'b0, 3'b001, 32'h201, 32'h0, 0, 1, 32'h0, 1'b0);
        do_access(1'b0, 1'b1, 3'b010, 32'h102, 32'h11223344, 0, 0, 32'h0, 1'b0);
        do_access(1'b1, 1'b0, 3'b011, 32'h200, 32'h0, 0, 1, 32'h0, 1'b0);
        do_access(1'b1, 1'b1, 3'b010, 32'h200, 32'h0, 0, 1, 32'h0, 1'b0);
        do_access(1'b0, 1'b1, 3'b100, 32'h200, 32'h0, 0, 1, 32'h0, 1'b0);

        // Timeout waiting for ready, then waiting for response.
        do_access(1'b1, 1'b0, 3'b010, 32'h400, 32'h0, NEVER, 1, 32'h0, 1'b0);
        chk("timeout_rdata_literal", o_ReadDataM, 32'h0);
        do_access(1'b1, 1'b0, 3'b010, 32'h500, 32'h0, 0, 1, 32'h89ABCDEF, 1'b0);
        do_access(1'b1, 1'b0, 3'b010, 32'h504, 32'h0, 0, NEVER, 32'h0, 1'b0);

        // Reset asserted during RESP; response arrives the following cycle.
        do_access(1'b1, 1'b0, 3'b010, 32'h600, 32'h0, 0, 1, 32'h76543210, 1'b0);
        step();
        i_MemReadM = 1'b1; i_Funct3M = 3'b010; i_ALUResultM = 32'h300;
        push(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0);
        step();
        i_BusReady = 1'b1;
        push(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h300, '0, 4'hF);
        step();
        i_BusReady = 1'b0;
        push(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0);
        step();
        i_Reset = 1'b0;
        push(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0);
        step();
        i_Reset = 1'b1;
        idle_in();
        i_BusRValid = 1'b1; i_BusRData = 32'h55AA55AA;
        cur_rd = 32'd0;
        push(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0);
        chk_zero("reset_in_resp");
        step();
        i_BusRValid = 1'b0;
        push(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0);

        // Recovery after reset.
        do_access(1'b0, 1'b1, 3'b001, 32'h700, 32'h0000C0DE, 0, 0, 32'h0, 1'b0);
        do_access(1'b1, 1'b0, 3'b000, 32'h703, 32'h0, 0, 1, 32'h7F000000, 1'b0);

        step();
        push(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0);
        @(negedge clk);
        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
